// File: rtl/cond_unit.sv
// Condition evaluation and NZCV status register for the single-cycle ARM controller.
// Gates PC/register/memory writes on the condition result and keeps debug retire counters.
module cond_unit #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [3:0]      Cond,
  input  logic [3:0]      ALUFlags,
  input  logic [1:0]      FlagW,
  input  logic            PCS,
  input  logic            RegW,
  input  logic            MemW,
  input  logic            NoWrite,
  input  logic            Stall,
  output logic            PCSrc,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            CondEx,
  output logic [3:0]      Flags,
  output logic [CNTW-1:0] ExecCount,
  output logic [CNTW-1:0] SkipCount
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [3:0]      flags_q;
  logic [CNTW-1:0] exec_q;
  logic [CNTW-1:0] skip_q;
  logic            flag_n;
  logic            flag_z;
  logic            flag_c;
  logic            flag_v;
  logic            cond_ok;
  logic            retire;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Evaluated only against the stored flags; ALUFlags never bypass into this cycle.
  always_comb begin
    cond_ok = 1'b0;
    case (Cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = ~flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = ~flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = ~flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = ~flag_v;
      4'b1000: cond_ok = flag_c & ~flag_z;
      4'b1001: cond_ok = ~flag_c | flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ok = flag_z | (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign retire   = ~Stall;
  assign CondEx   = cond_ok;
  assign PCSrc    = PCS & cond_ok & retire;
  assign RegWrite = RegW & cond_ok & ~NoWrite & retire;
  assign MemWrite = MemW & cond_ok & retire;

  assign Flags     = flags_q;
  assign ExecCount = exec_q;
  assign SkipCount = skip_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      flags_q <= 4'b0000;
      exec_q  <= '0;
      skip_q  <= '0;
    end else if (retire) begin
      if (cond_ok) begin
        if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
        if (exec_q != CNT_MAX) exec_q <= exec_q + CNT_ONE;
      end else begin
        if (skip_q != CNT_MAX) skip_q <= skip_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus queues expected values, a negedge monitor checks them.
// A second instance with 4-bit counters shares all inputs and covers saturation.
module tb_cond_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS, RegW, MemW, NoWrite, Stall;

  logic        PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]  Flags;
  logic [15:0] ExecCount, SkipCount;

  logic        PCSrc4, RegWrite4, MemWrite4, CondEx4;
  logic [3:0]  Flags4;
  logic [3:0]  ExecCount4, SkipCount4;

  always #5 clk = ~clk;

  cond_unit #(.CNTW(16)) dut (
    .clk(clk), .resetn(resetn), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Stall(Stall),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .ExecCount(ExecCount), .SkipCount(SkipCount)
  );

  cond_unit #(.CNTW(4)) dut4 (
    .clk(clk), .resetn(resetn), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Stall(Stall),
    .PCSrc(PCSrc4), .RegWrite(RegWrite4), .MemWrite(MemWrite4), .CondEx(CondEx4),
    .Flags(Flags4), .ExecCount(ExecCount4), .SkipCount(SkipCount4)
  );

  typedef enum int {S_PCSRC, S_REGW, S_MEMW, S_CONDEX, S_FLAGS,
                    S_EXEC, S_SKIP, S_EXEC4, S_SKIP4} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_val(input string name, input sel_t sel, input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    q.push_back(e);
  endtask

  function automatic logic [15:0] pick(input sel_t sel);
    case (sel)
      S_PCSRC:  return {15'd0, PCSrc};
      S_REGW:   return {15'd0, RegWrite};
      S_MEMW:   return {15'd0, MemWrite};
      S_CONDEX: return {15'd0, CondEx};
      S_FLAGS:  return {12'd0, Flags};
      S_EXEC:   return ExecCount;
      S_SKIP:   return SkipCount;
      S_EXEC4:  return {12'd0, ExecCount4};
      S_SKIP4:  return {12'd0, SkipCount4};
      default:  return 16'hdead;
    endcase
  endfunction

  // Monitor: outputs are presented every cycle, so drain whatever was queued for it.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = pick(e.sel);
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %0h expected %0h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  // Reference condition table written from the instruction-set definition.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic rn, input logic [3:0] c, input logic [3:0] af,
                     input logic [1:0] fw, input logic pcs_i, input logic regw_i,
                     input logic memw_i, input logic nw, input logic st);
    resetn = rn; Cond = c; ALUFlags = af; FlagW = fw;
    PCS = pcs_i; RegW = regw_i; MemW = memw_i; NoWrite = nw; Stall = st;
  endtask

  task automatic state_chk(input string tag, input logic [3:0] f,
                           input logic [15:0] ex, input logic [15:0] sk);
    expect_val({tag, "_flags"}, S_FLAGS, {12'd0, f});
    expect_val({tag, "_exec"},  S_EXEC,  ex);
    expect_val({tag, "_skip"},  S_SKIP,  sk);
  endtask

  initial begin
    set(1'b0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held two edges with flag writes requested.
    for (int i = 0; i < 2; i++) begin
      cyc();
      state_chk("reset", 4'b0000, 16'd0, 16'd0);
      expect_val("reset_regwrite", S_REGW, 16'd1);
      expect_val("reset_condex",   S_CONDEX, 16'd1);
    end

    // Flag write groups
    cyc();
    set(1'b1, 4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    state_chk("grp1_pre", 4'b0000, 16'd0, 16'd0);
    cyc();
    set(1'b1, 4'b1110, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    state_chk("grp1", 4'b1100, 16'd1, 16'd0);
    cyc();
    set(1'b1, 4'b1110, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    state_chk("grp2", 4'b1100, 16'd2, 16'd0);
    cyc();
    set(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    state_chk("grp3", 4'b1111, 16'd3, 16'd0);

    // Failed condition: NE with Z=1
    cyc();
    set(1'b1, 4'b0001, 4'b1010, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    state_chk("fail_pre", 4'b0100, 16'd4, 16'd0);
    expect_val("fail_condex", S_CONDEX, 16'd0);
    expect_val("fail_pcsrc",  S_PCSRC,  16'd0);
    expect_val("fail_regw",   S_REGW,   16'd0);
    expect_val("fail_memw",   S_MEMW,   16'd0);

    // Compare-type instruction: no register write, flags still written
    cyc();
    set(1'b1, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    state_chk("fail_post", 4'b0100, 16'd4, 16'd1);
    expect_val("cmp_regw",   S_REGW,   16'd0);
    expect_val("cmp_condex", S_CONDEX, 16'd1);

    // Stall for three cycles with every write requested
    for (int i = 0; i < 3; i++) begin
      cyc();
      set(1'b1, 4'b1110, 4'b0001, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      state_chk("stall", 4'b1000, 16'd5, 16'd1);
      expect_val("stall_regw",   S_REGW,   16'd0);
      expect_val("stall_pcsrc",  S_PCSRC,  16'd0);
      expect_val("stall_memw",   S_MEMW,   16'd0);
      expect_val("stall_condex", S_CONDEX, 16'd1);
    end

    // Unstalled: MI with N=1 passes, writes enabled
    cyc();
    set(1'b1, 4'b0100, 4'b0100, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    state_chk("unstall", 4'b1000, 16'd5, 16'd1);
    expect_val("unstall_pcsrc", S_PCSRC, 16'd1);
    expect_val("unstall_regw",  S_REGW,  16'd1);
    expect_val("unstall_memw",  S_MEMW,  16'd1);

    // Back-to-back: EQ now sees Z=1 written by the previous instruction
    cyc();
    set(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    state_chk("b2b", 4'b0100, 16'd6, 16'd1);
    expect_val("b2b_condex", S_CONDEX, 16'd1);
    expect_val("b2b_regw",   S_REGW,   16'd1);

    // Mid-program reset during a stall with flag writes requested
    cyc();
    set(1'b0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc();
    set(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    state_chk("midrst", 4'b0000, 16'd0, 16'd0);
    expect_val("midrst_eq", S_CONDEX, 16'd0);
    cyc();
    set(1'b1, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_val("midrst_ne", S_CONDEX, 16'd1);

    // Explicit spot checks with Flags=0100
    cyc();
    set(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    set(1'b1, 4'b1101, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_val("z_le", S_CONDEX, 16'd1);
    cyc();
    set(1'b1, 4'b1100, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_val("z_gt", S_CONDEX, 16'd0);

    // Exhaustive condition sweep: load flags, then evaluate all codes while stalled
    for (int f = 0; f < 16; f++) begin
      cyc();
      set(1'b1, 4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) begin
        cyc();
        set(1'b1, 4'(c), 4'(15 - f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (c == 0) expect_val("sweep_flags", S_FLAGS, 16'(f));
        expect_val($sformatf("cond_f%0h_c%0h", f, c), S_CONDEX,
                   {15'd0, ref_cond(4'(c), 4'(f))});
      end
    end

    // Saturation: both instances reset, then 20 AL retires
    cyc();
    set(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 20; i++) begin
      cyc();
      set(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, (i == 20));
      expect_val($sformatf("sat_exec4_%0d", i), S_EXEC4, (i > 15) ? 16'd15 : 16'(i));
      expect_val($sformatf("sat_skip4_%0d", i), S_SKIP4, 16'd0);
      expect_val($sformatf("sat_exec16_%0d", i), S_EXEC, 16'(i));
    end
    cyc();
    expect_val("sat_final_exec4", S_EXEC4, 16'd15);
    expect_val("sat_final_exec16", S_EXEC, 16'd20);

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
